pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Inverse of the one-pulse edge shaper: takes active-low one-cycle pulses and
//  re-expands each one into a fixed-width active-high level on out_level.
//  Consecutive output levels are separated by a guaranteed gap.
//  Pulses that arrive while an output is in progress are counted and replayed.
//  Drives LEDs and buzzers, and feeds slow consumers from button-pulse logic.
// PARAMETERS
//  HIGH_CYCLES  4  width of each output level in clk cycles (>=1)
//  GAP_CYCLES   2  minimum low cycles between output levels (>=0)
//  PEND_W       3  width of the pending counter; at most 2**PEND_W-1 queued
// PORTS
//  clk         in   1       system clock, all logic on rising edge
//  rst         in   1       synchronous reset, active-high
//  in_pulse_n  in   1       active-low trigger, idle 1
//  clr_ovf     in   1       synchronous clear of overflow, active-high
//  out_level   out  1       stretched output, active-high
//  busy        out  1       1 whenever state != IDLE
//  pend_cnt    out  PEND_W  number of queued, not-yet-replayed pulses
//  overflow    out  1       sticky: a pulse was dropped because the queue was full
// BEHAVIOUR
//  Reset:
//   - state=IDLE; out_level=0, busy=0, pend_cnt=0, overflow=0.
//   - Input history register = 1, so a reset released while in_pulse_n is low
//     does not register an event.
//  Event detection:
//   - event = ~in_pulse_n & prev_in, where prev_in is in_pulse_n registered.
//   - A low held for N cycles is one event (falling edge only).
//  Timing and outputs:
//   - An event sampled at edge k in IDLE gives out_level=1 from edge k+1.
//   - All outputs are registered; none are combinational from inputs.
//  FSM:
//   - IDLE -> HIGH on event; counter loaded with HIGH_CYCLES-1.
//   - HIGH: out_level=1. When counter==0 -> GAP, counter loaded with
//     GAP_CYCLES-1. If GAP_CYCLES==0, skip GAP and apply the GAP-exit rule directly.
//   - GAP: out_level=0. When counter==0 -> HIGH with pend_cnt-1 if pend_cnt>0,
//     else -> IDLE.
//  Queueing:
//   - An event in HIGH or GAP increments pend_cnt.
//   - At the max value, pend_cnt holds and overflow is set to 1.
//   - An event in IDLE never touches pend_cnt.
//  Simultaneous events:
//   - Event in the same cycle as a GAP-exit dequeue: net pend_cnt unchanged;
//     the new event is not dropped, even if pend_cnt is at max.
//   - clr_ovf together with a new overflow: set wins.
//  Reset mid-operation: everything returns to reset values on the next edge;
//  queued pulses are discarded.
//  Counter width: $clog2(max(HIGH_CYCLES,GAP_CYCLES,2)); no wrap, always reloaded.
// STRUCTURE
//  Shared package pulse_pkg:
//   - state enum {IDLE,HIGH,GAP} (2 bits).
//   - Counter-width helper function.
//  Sub-module fall_detect (clk, rst, in_n, event_o):
//   - history flop reset to 1, one-cycle event output.
//   - Reusable by other pulse-consuming blocks.
//  Top level holds the FSM, the shared down-counter, the pending counter and overflow.
// TESTING  (defaults HIGH=4, GAP=2, PEND_W=3; cycle = rising-edge index)
//  1 Single low at edge 10 -> out_level=1 at edges 11..14, 0 at 15..16;
//    busy 11..16, then 0 at 17; pend_cnt stays 0.
//  2 Lows at edges 10 and 12 -> pend_cnt=1 at 13; second level at 17..20;
//    pend_cnt=0 from 17; busy drops at 23.
//  3 Nine separate lows during one busy period -> pend_cnt saturates at 7 and
//    overflow=1; clr_ovf pulse -> overflow=0 next edge; seven more levels replay.
//  4 in_pulse_n held low for 20 cycles from edge 10 -> exactly one level
//    (11..14); no further activity.
//  5 With pend_cnt=1, new event on the last GAP cycle -> next HIGH starts;
//    pend_cnt stays 1.
//  6 rst=1 at edge 12 (mid-HIGH) with pend_cnt=2 -> at 13 all outputs are 0;
//    in_pulse_n low during and after reset -> no event until it returns high then low.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and helpers for the pulse stretcher and other pulse-consuming blocks.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Down-counter width large enough for either phase length; never below 1 bit.
  function automatic int cnt_width(input int high_cycles, input int gap_cycles);
    int m;
    m = 2;
    if (high_cycles > m) m = high_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/fall_detect.sv
// Falling-edge detector for an active-low, idle-high trigger line.
module fall_detect (
  input  logic clk,
  input  logic rst,
  input  logic in_n,
  output logic event_o
);

  logic hist;
  logic armed;

  // armed stays low until the line has been seen high after reset, so a line
  // that is still low when reset releases cannot fake a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist  <= 1'b1;
      armed <= 1'b0;
    end else begin
      hist <= in_n;
      if (in_n) armed <= 1'b1;
    end
  end

  assign event_o = ~in_n & hist & armed;

endmodule

// File: rtl/pulse_stretcher.sv
// Re-expands active-low one-cycle pulses into fixed-width high levels with a
// guaranteed gap between them; pulses arriving while busy are queued and replayed.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_pulse_n,
  input  logic              clr_ovf,
  output logic              out_level,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow,
  output state_t            state_dbg
);

  localparam int CW = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0]     HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0]     GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t            state, state_nx;
  logic [CW-1:0]     cnt, cnt_nx;
  logic [PEND_W-1:0] pend_nx;
  logic              ovf_nx;
  logic              ev;
  logic              leave_gap;
  logic              ev_queued;

  fall_detect u_fall_detect (
    .clk    (clk),
    .rst    (rst),
    .in_n   (in_pulse_n),
    .event_o(ev)
  );

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    leave_gap = 1'b0;
    case (state)
      IDLE: begin
        if (ev) begin
          state_nx = HIGH;
          cnt_nx   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          if (GAP_CYCLES == 0) begin
            leave_gap = 1'b1;
          end else begin
            state_nx = GAP;
            cnt_nx   = GAP_LOAD;
          end
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) leave_gap = 1'b1;
        else           cnt_nx = cnt - 1'b1;
      end
      default: state_nx = IDLE;
    endcase
    // A pulse landing on the exit cycle starts the next level directly.
    if (leave_gap) begin
      if (pend_cnt != '0 || ev) begin
        state_nx = HIGH;
        cnt_nx   = HIGH_LOAD;
      end else begin
        state_nx = IDLE;
      end
    end
  end

  assign ev_queued = ev && (state != IDLE);

  always_comb begin
    pend_nx = pend_cnt;
    ovf_nx  = overflow & ~clr_ovf;
    if (ev_queued && leave_gap) begin
      pend_nx = pend_cnt;
    end else if (leave_gap && pend_cnt != '0) begin
      pend_nx = pend_cnt - 1'b1;
    end else if (ev_queued) begin
      if (pend_cnt == PEND_MAX) ovf_nx = 1'b1;
      else                      pend_nx = pend_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pend_cnt  <= '0;
      overflow  <= 1'b0;
      out_level <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend_cnt  <= pend_nx;
      overflow  <= ovf_nx;
      out_level <= (state_nx == HIGH);
      busy      <= (state_nx != IDLE);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher at default parameters (HIGH=4, GAP=2, PEND_W=3).
module tb_pulse_stretcher;
  import pulse_pkg::*;

  localparam int PEND_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_pulse_n;
  logic              clr_ovf;
  logic              out_level;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              overflow;
  state_t            state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic              in_n;
    logic              clr;
    logic              r;
    logic              e_out;
    logic              e_busy;
    logic [PEND_W-1:0] e_pend;
    logic              e_ovf;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pulse_stretcher #(
    .HIGH_CYCLES(4),
    .GAP_CYCLES (2),
    .PEND_W     (PEND_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pulse_n(in_pulse_n),
    .clr_ovf   (clr_ovf),
    .out_level (out_level),
    .busy      (busy),
    .pend_cnt  (pend_cnt),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Inputs are applied for the next rising edge; outputs read 1 time unit after it.
  task automatic tick(input logic in_n, input logic clr, input logic r);
    in_pulse_n = in_n;
    clr_ovf    = clr;
    rst        = r;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic in_n, input logic clr, input logic r,
                              input logic o, input logic b, input int p, input logic v);
    vec_t t;
    t.in_n = in_n; t.clr = clr; t.r = r;
    t.e_out = o; t.e_busy = b; t.e_pend = PEND_W'(p); t.e_ovf = v;
    vecs.push_back(t);
  endfunction

  function automatic void add_n(input int n, input logic in_n, input logic o,
                                input logic b, input int p);
    for (int i = 0; i < n; i++) add(in_n, 1'b0, 1'b0, o, b, p, 1'b0);
  endfunction

  // Two reset cycles then three idle cycles; all outputs must read zero.
  function automatic void add_reset_idle();
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add_n(3, 1'b1, 1'b0, 1'b0, 0);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      tick(vecs[i].in_n, vecs[i].clr, vecs[i].r);
      check($sformatf("%s[%0d].out_level", tag, i), 32'(out_level), 32'(vecs[i].e_out));
      check($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].e_busy));
      check($sformatf("%s[%0d].pend_cnt", tag, i), 32'(pend_cnt), 32'(vecs[i].e_pend));
      check($sformatf("%s[%0d].overflow", tag, i), 32'(overflow), 32'(vecs[i].e_ovf));
    end
    vecs.delete();
  endtask

  initial begin
    int   levels;
    logic prev;

    rst = 1'b1; in_pulse_n = 1'b1; clr_ovf = 1'b0;

    // Single pulse: four high cycles, two gap cycles, then idle.
    add_reset_idle();
    add_n(1, 1'b0, 1'b1, 1'b1, 0);
    add_n(3, 1'b1, 1'b1, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b0, 0);
    run_vecs("single");
    check("single.state_idle", 32'(state_dbg), 32'(IDLE));

    // Second pulse while high is queued and replayed after the gap.
    add_reset_idle();
    add_n(1, 1'b0, 1'b1, 1'b1, 0);
    add_n(1, 1'b1, 1'b1, 1'b1, 0);
    add_n(1, 1'b0, 1'b1, 1'b1, 1);
    add_n(1, 1'b1, 1'b1, 1'b1, 1);
    add_n(2, 1'b1, 1'b0, 1'b1, 1);
    add_n(4, 1'b1, 1'b1, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b0, 0);
    run_vecs("queue");

    // Long low is a single event.
    add_reset_idle();
    add_n(4, 1'b0, 1'b1, 1'b1, 0);
    add_n(2, 1'b0, 1'b0, 1'b1, 0);
    add_n(14, 1'b0, 1'b0, 1'b0, 0);
    add_n(2, 1'b1, 1'b0, 1'b0, 0);
    run_vecs("hold_low");

    // New pulse on the last gap cycle while one is pending: count stays 1.
    add_reset_idle();
    add_n(1, 1'b0, 1'b1, 1'b1, 0);
    add_n(1, 1'b1, 1'b1, 1'b1, 0);
    add_n(1, 1'b0, 1'b1, 1'b1, 1);
    add_n(1, 1'b1, 1'b1, 1'b1, 1);
    add_n(2, 1'b1, 1'b0, 1'b1, 1);
    add_n(1, 1'b0, 1'b1, 1'b1, 1);
    add_n(3, 1'b1, 1'b1, 1'b1, 1);
    add_n(2, 1'b1, 1'b0, 1'b1, 1);
    add_n(4, 1'b1, 1'b1, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b1, 0);
    add_n(2, 1'b1, 1'b0, 1'b0, 0);
    run_vecs("gap_exit");

    // Reset mid-high with two pending, input held low through and after reset.
    add_reset_idle();
    add_n(1, 1'b0, 1'b1, 1'b1, 0);
    add_n(1, 1'b1, 1'b1, 1'b1, 0);
    add_n(1, 1'b0, 1'b1, 1'b1, 1);
    add_n(1, 1'b1, 1'b1, 1'b1, 1);
    add_n(1, 1'b0, 1'b0, 1'b1, 2);
    add_n(1, 1'b1, 1'b0, 1'b1, 2);
    add_n(1, 1'b0, 1'b1, 1'b1, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add_n(2, 1'b0, 1'b0, 1'b0, 0);
    add_n(1, 1'b1, 1'b0, 1'b0, 0);
    add_n(1, 1'b0, 1'b1, 1'b1, 0);
    add_n(1, 1'b1, 1'b1, 1'b1, 0);
    run_vecs("mid_reset");

    // Saturation and overflow: lows on every other edge for 31 edges.
    add_reset_idle();
    run_vecs("sat_reset");
    for (int k = 10; k <= 40; k++) begin
      tick((k % 2) != 0, 1'b0, 1'b0);
      if (k == 30) begin
        check("sat.pend_at_max", 32'(pend_cnt), 32'd7);
        check("sat.ovf_not_yet", 32'(overflow), 32'd0);
      end
      if (k == 32) check("sat.ovf_set", 32'(overflow), 32'd1);
    end
    check("sat.exit_high", 32'(out_level), 32'd1);
    check("sat.exit_pend_held", 32'(pend_cnt), 32'd7);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("sat.set_beats_clear", 32'(overflow), 32'd1);
    check("sat.pend_still_max", 32'(pend_cnt), 32'd7);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("sat.ovf_cleared", 32'(overflow), 32'd0);
    levels = 0;
    prev   = out_level;
    for (int n = 0; n < 200 && busy; n++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (out_level && !prev) levels++;
      prev = out_level;
    end
    check("sat.replay_levels", 32'(levels), 32'd7);
    check("sat.drained_idle", 32'(busy), 32'd0);
    check("sat.drained_pend", 32'(pend_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
